// File: rtl/down_counter_timer.sv
// Loadable, enable-gated down counter/timer with one-shot and auto-reload modes.
// Optional build macro DOWN_CNT_PRESCALE_EN divides en-qualified cycles by PRESCALE.
module down_counter_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             en,
  output logic [WIDTH-1:0] cout,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cout_q, cout_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  // step: this en-qualified RUN cycle is allowed to decrement.
  logic             step;
  logic             presc_clr;
  logic             presc_inc;

`ifdef DOWN_CNT_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;

  assign step = (presc_q == PW'(PRESCALE - 1));

  always_comb begin
    presc_d = presc_q;
    if (presc_clr) begin
      presc_d = '0;
    end else if (presc_inc) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  logic unused_prescale;

  assign step            = 1'b1;
  assign unused_prescale = (PRESCALE != 0) ^ presc_clr ^ presc_inc;
`endif

  // Priority per edge: load, then en-qualified counting in RUN, then hold.
  always_comb begin
    state_d   = state_q;
    cout_d    = cout_q;
    reload_d  = reload_q;
    mode_d    = mode_q;
    tc_d      = 1'b0;
    presc_clr = 1'b0;
    presc_inc = 1'b0;

    if (load) begin
      reload_d  = load_val;
      mode_d    = mode;
      cout_d    = load_val;
      presc_clr = 1'b1;
      state_d   = (load_val != '0) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (en) begin
            if (!step) begin
              presc_inc = 1'b1;
            end else begin
              presc_clr = 1'b1;
              if (cout_q > WIDTH'(1)) begin
                cout_d = cout_q - WIDTH'(1);
              end else if (cout_q == WIDTH'(1)) begin
                tc_d = 1'b1;
                if (mode_q) begin
                  cout_d = reload_q;
                end else begin
                  cout_d  = '0;
                  state_d = DONE;
                end
              end else begin
                // A zero count cannot run; fall back to IDLE rather than wrap.
                state_d = IDLE;
              end
            end
          end
        end
        IDLE, DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cout_q   <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cout_q   <= cout_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end

  assign cout = cout_q;
  assign tc   = tc_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer (WIDTH=4, PRESCALE=4).
// Outputs are sampled on the falling clock edge; inputs change right after sampling.
module tb_down_counter_timer;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         load;
  logic [W-1:0] load_val;
  logic         mode;
  logic         en;
  logic [W-1:0] cout;
  logic         tc;
  logic         busy;

  int errors;
  int checks;

  down_counter_timer #(.WIDTH(W), .PRESCALE(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .en       (en),
    .cout     (cout),
    .tc       (tc),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a load for exactly one rising edge; returns at the following falling edge.
  task automatic do_load(input logic [W-1:0] val, input logic m, input logic e);
    load     = 1'b1;
    load_val = val;
    mode     = m;
    en       = e;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    load = 1'b0; load_val = '0; mode = 1'b0; en = 1'b0;
    @(negedge clk);
    checks++;
    if (cout !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: cout=%0d tc=%b busy=%b expected 0 0 0", cout, tc, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    // Run to 7, then assert reset between edges.
    do_load(4'd9, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cout !== 4'd7 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre: cout=%0d busy=%b expected 7 1", cout, busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (cout !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: cout=%0d tc=%b busy=%b expected 0 0 0", cout, tc, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (cout !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: cout=%0d busy=%b tc=%b expected 0 0 0", i, cout, busy, tc);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_one_shot();
    logic [W-1:0] exp_c [8] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    logic         exp_t [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic         exp_b [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_load(4'd5, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (cout !== exp_c[i] || tc !== exp_t[i] || busy !== exp_b[i]) begin
        errors++;
        $display("FAIL one_shot[%0d]: cout=%0d tc=%b busy=%b expected %0d %b %b",
                 i, cout, tc, busy, exp_c[i], exp_t[i], exp_b[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_auto_reload();
    logic [W-1:0] exp_c [8] = '{4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2};
    logic         exp_t [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    do_load(4'd3, 1'b1, 1'b1);
    // Mode changes without a load must not affect the running counter.
    mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (cout !== exp_c[i] || tc !== exp_t[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL auto_reload[%0d]: cout=%0d tc=%b busy=%b expected %0d %b 1",
                 i, cout, tc, busy, exp_c[i], exp_t[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_en_gating();
    logic [W-1:0] exp_c [8] = '{4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
    logic         en_pat [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_load(4'd4, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (cout !== exp_c[i] || tc !== (i == 7)) begin
        errors++;
        $display("FAIL en_gating[%0d]: cout=%0d tc=%b expected %0d %b", i, cout, tc, exp_c[i], (i == 7));
      end
      en = en_pat[i];
    end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_load(4'd2, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (cout !== 4'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pre: cout=%0d busy=%b expected 1 1", cout, busy);
    end
    // Load wins over the expiry that en would otherwise cause this edge.
    do_load(4'd9, 1'b0, 1'b1);
    checks++;
    if (cout !== 4'd9 || tc !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_load9: cout=%0d tc=%b busy=%b expected 9 0 1", cout, tc, busy);
    end
    do_load(4'd0, 1'b1, 1'b1);
    checks++;
    if (cout !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_load0: cout=%0d tc=%b busy=%b expected 0 0 0", cout, tc, busy);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (cout !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle[%0d]: cout=%0d tc=%b busy=%b expected 0 0 0", i, cout, tc, busy);
      end
    end
    do_load(4'd15, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (cout !== 4'(15 - i) || tc !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_load15[%0d]: cout=%0d tc=%b busy=%b expected %0d 0 1", i, cout, tc, busy, 15 - i);
      end
    end
    en = 1'b0;
  endtask

`ifdef DOWN_CNT_PRESCALE_EN
  task automatic test_prescale();
    logic [W-1:0] exp_c;
    do_load(4'd2, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      exp_c = (i < 4) ? 4'd2 : ((i < 8) ? 4'd1 : 4'd0);
      checks++;
      if (cout !== exp_c || tc !== (i == 8) || busy !== (i < 8)) begin
        errors++;
        $display("FAIL prescale[%0d]: cout=%0d tc=%b busy=%b expected %0d %b %b",
                 i, cout, tc, busy, exp_c, (i == 8), (i < 8));
      end
    end
    en = 1'b0;
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
`ifdef DOWN_CNT_PRESCALE_EN
    test_reset();
    test_prescale();
`else
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_en_gating();
    test_back_to_back();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
